pipeline_hazard_ctrl: RTL and testbench

- Sequencing controller for the pipelined fetch unit and the IF/ID and ID/EX pipeline registers.
- Owns four jobs:
  - Boot: drives pcSelect so the PC loads startAddress.
  - Hazard stalls: load-use, and branch/jump-register operands produced by the instruction in EX.
  - Flushes: bubbles into IF/ID and ID/EX after taken branches, jumps and stalls.
  - End-of-program drain: freezes fetch and lets in-flight instructions retire, then reports halted.
- Also counts stall cycles for performance debug.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / sequencing controller.
//   - state_t     : controller state encoding
//   - NOP_INSTR   : instruction word a flushed pipeline register holds
//   - REG_ZERO    : hard-wired zero register index
//   - reg_is_live : true when a register index can carry a real dependency
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // The all-zero word decodes as a NOP, so a flushed register simply clears.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Writes to r0 are discarded, so r0 can never create a hazard.
  function automatic logic reg_is_live(input logic [4:0] reg_idx);
    return (reg_idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : datapath side, drives EX/ID fields, start and endProgram,
//            receives the sequencing controls.
//   slave  : controller side, the mirror image.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_hazard_ctrl_pkg::*;

  logic             start;
  logic             memReadEx;
  logic             regWriteEx;
  logic [4:0]       rdEx;
  logic [4:0]       rs1Id;
  logic [4:0]       rs2Id;
  logic             useRs1Id;
  logic             useRs2Id;
  logic             branchRegId;
  logic             branchTaken;
  logic             jumpId;
  logic             endProgram;

  logic             pcSelect;
  logic             stall;
  logic             flushIfId;
  logic             flushIdEx;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output start, memReadEx, regWriteEx, rdEx, rs1Id, rs2Id, useRs1Id,
           useRs2Id, branchRegId, branchTaken, jumpId, endProgram,
    input  pcSelect, stall, flushIfId, flushIdEx, running, halted, stallCount
  );

  modport slave (
    input  start, memReadEx, regWriteEx, rdEx, rs1Id, rs2Id, useRs1Id,
           useRs2Id, branchRegId, branchTaken, jumpId, endProgram,
    output pcSelect, stall, flushIfId, flushIdEx, running, halted, stallCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Purely combinational hazard detection from the EX and ID fields.
//   lu_haz : the load in EX produces a register the ID instruction reads.
//   br_haz : a branch/jump-register in ID needs rs1 from the instruction in
//            EX; rs1 is consumed in ID where no forwarding path exists.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       mem_read_ex,
  input  logic       reg_write_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic       branch_reg_id,
  output logic       lu_haz,
  output logic       br_haz
);

  logic rd_live_s;
  logic rs1_match_s;
  logic rs2_match_s;

  assign rd_live_s   = reg_is_live(rd_ex);
  assign rs1_match_s = (rd_ex == rs1_id);
  assign rs2_match_s = (rd_ex == rs2_id);

  assign lu_haz = mem_read_ex & rd_live_s &
                  ((use_rs1_id & rs1_match_s) | (use_rs2_id & rs2_match_s));

  assign br_haz = branch_reg_id & reg_write_ex & rd_live_s & rs1_match_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the fetch unit and IF/ID, ID/EX registers.
// Boots the PC from startAddress, stalls on load-use and branch-operand
// hazards, flushes wrong-path fetches, drains the pipe at end of program
// and counts hazard stall cycles (saturating).
// Ports:
//   clk    : rising-edge clock
//   resetN : asynchronous active-low reset
//   bus    : slave side of pipeline_hazard_ctrl_if (EX/ID fields, start,
//            endProgram in; pcSelect, stall, flushes, running, halted,
//            stallCount out)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_r;
  logic [DW-1:0]    drain_cnt_r;
  logic [CNT_W-1:0] stall_count_r;

  logic lu_haz_s;
  logic br_haz_s;
  logic hazard_s;
  logic redirect_s;

  logic pc_select_s;
  logic stall_s;
  logic flush_if_id_s;
  logic flush_id_ex_s;
  logic running_s;
  logic halted_s;

  pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
    .mem_read_ex   (bus.memReadEx),
    .reg_write_ex  (bus.regWriteEx),
    .rd_ex         (bus.rdEx),
    .rs1_id        (bus.rs1Id),
    .rs2_id        (bus.rs2Id),
    .use_rs1_id    (bus.useRs1Id),
    .use_rs2_id    (bus.useRs2Id),
    .branch_reg_id (bus.branchRegId),
    .lu_haz        (lu_haz_s),
    .br_haz        (br_haz_s)
  );

  assign hazard_s   = lu_haz_s | br_haz_s;
  assign redirect_s = bus.branchTaken | bus.jumpId;

  // State register, drain countdown and saturating stall counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= ST_IDLE;
      drain_cnt_r   <= {DW{1'b0}};
      stall_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            state_r       <= ST_BOOT;
            stall_count_r <= {CNT_W{1'b0}};
          end
        end
        ST_BOOT: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (hazard_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
          end
          // An end marker beside a redirect is wrong-path; beside a stall
          // it is simply seen again next cycle.
          if (bus.endProgram && !redirect_s && !hazard_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == {DW{1'b0}}) begin
            state_r <= ST_HALT;
          end else begin
            drain_cnt_r <= drain_cnt_r - DW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from state and current hazard/redirect inputs.
  always_comb begin
    pc_select_s   = 1'b1;
    stall_s       = 1'b1;
    flush_if_id_s = 1'b1;
    flush_id_ex_s = 1'b1;
    running_s     = 1'b0;
    halted_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pc_select_s = 1'b1;
      end
      ST_BOOT: begin
        stall_s       = 1'b0;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        running_s     = 1'b1;
      end
      ST_RUN: begin
        pc_select_s   = 1'b0;
        stall_s       = hazard_s;
        flush_id_ex_s = hazard_s;
        // Stall wins: the redirect is re-evaluated once the hazard clears.
        flush_if_id_s = ~hazard_s & redirect_s;
        running_s     = 1'b1;
      end
      ST_DRAIN: begin
        pc_select_s   = 1'b0;
        flush_id_ex_s = 1'b0;
        running_s     = 1'b1;
      end
      ST_HALT: begin
        halted_s = 1'b1;
      end
      default: begin
        halted_s = 1'b0;
      end
    endcase
  end

  assign bus.pcSelect   = pc_select_s;
  assign bus.stall      = stall_s;
  assign bus.flushIfId  = flush_if_id_s;
  assign bus.flushIdEx  = flush_id_ex_s;
  assign bus.running    = running_s;
  assign bus.halted     = halted_s;
  assign bus.stallCount = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string       tag;
    logic [5:0]  flags;   // {pcSelect, stall, flushIfId, flushIdEx, running, halted}
    logic [15:0] cnt;
  } exp_t;

  // Expected flag patterns
  localparam logic [5:0] F_IDLE   = 6'b111100;
  localparam logic [5:0] F_BOOT   = 6'b100010;
  localparam logic [5:0] F_RUN    = 6'b000010;
  localparam logic [5:0] F_STALL  = 6'b010110;
  localparam logic [5:0] F_REDIR  = 6'b001010;
  localparam logic [5:0] F_DRAIN  = 6'b011010;
  localparam logic [5:0] F_HALT   = 6'b111101;

  logic clk;
  logic resetN;
  exp_t sb[$];
  int   n_pass;
  int   n_total;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    bus.start       = 1'b0;
    bus.memReadEx   = 1'b0;
    bus.regWriteEx  = 1'b0;
    bus.rdEx        = 5'd0;
    bus.rs1Id       = 5'd0;
    bus.rs2Id       = 5'd0;
    bus.useRs1Id    = 1'b0;
    bus.useRs2Id    = 1'b0;
    bus.branchRegId = 1'b0;
    bus.branchTaken = 1'b0;
    bus.jumpId      = 1'b0;
    bus.endProgram  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] f, input logic [15:0] c);
    exp_t e;
    e.tag   = tag;
    e.flags = f;
    e.cnt   = c;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [5:0] obs;
    obs = {bus.pcSelect, bus.stall, bus.flushIfId, bus.flushIdEx, bus.running, bus.halted};
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      n_total++;
      assert (obs === e.flags) n_pass++;
      else $error("FAIL %s flags got %b want %b", e.tag, obs, e.flags);
      n_total++;
      assert (bus.stallCount === e.cnt) n_pass++;
      else $error("FAIL %s stallCount got %h want %h", e.tag, bus.stallCount, e.cnt);
    end
  endtask

  // Queue expectation, sample on the falling edge, then advance one cycle.
  task automatic step(input string tag, input logic [5:0] f, input logic [15:0] c);
    expect_out(tag, f, c);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clr();
    resetN = 1'b0;
    #12;
    expect_out("in_reset", F_IDLE, 16'd0);
    check();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    step("idle", F_IDLE, 16'd0);
    bus.start = 1'b1;
    step("idle_start", F_IDLE, 16'd0);
    clr();
    step("boot", F_BOOT, 16'd0);
    step("run", F_RUN, 16'd0);

    // Load-use on rs2
    bus.memReadEx = 1'b1; bus.rdEx = 5'd5; bus.rs2Id = 5'd5; bus.useRs2Id = 1'b1;
    step("load_use", F_STALL, 16'd0);
    clr();
    step("after_lu", F_RUN, 16'd1);

    // Branch-register hazard with simultaneous jump: stall wins
    bus.regWriteEx = 1'b1; bus.rdEx = 5'd3; bus.branchRegId = 1'b1;
    bus.rs1Id = 5'd3; bus.jumpId = 1'b1;
    step("br_haz_jump", F_STALL, 16'd1);
    bus.regWriteEx = 1'b0;
    step("jump_retry", F_REDIR, 16'd2);
    clr();

    // r0 never stalls
    bus.memReadEx = 1'b1; bus.rdEx = 5'd0; bus.rs1Id = 5'd0; bus.useRs1Id = 1'b1;
    step("zero_reg", F_RUN, 16'd2);
    // Matching rs2 that is not read does not stall
    bus.rdEx = 5'd5; bus.rs1Id = 5'd6; bus.rs2Id = 5'd5; bus.useRs2Id = 1'b0;
    step("unused_rs2", F_RUN, 16'd2);
    clr();

    // endProgram beside a stall: stays in RUN
    bus.memReadEx = 1'b1; bus.rdEx = 5'd7; bus.rs1Id = 5'd7; bus.useRs1Id = 1'b1;
    bus.endProgram = 1'b1;
    step("end_stall", F_STALL, 16'd2);
    clr();
    // endProgram beside a taken branch: wrong-path, ignored
    bus.endProgram = 1'b1; bus.branchTaken = 1'b1;
    step("end_redirect", F_REDIR, 16'd3);
    clr();
    bus.endProgram = 1'b1;
    step("end_accept", F_RUN, 16'd3);
    clr();

    // Drain: four cycles, inputs ignored
    bus.start = 1'b1; bus.memReadEx = 1'b1; bus.rdEx = 5'd9; bus.rs1Id = 5'd9; bus.useRs1Id = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), F_DRAIN, 16'd3);
    clr();
    step("halt", F_HALT, 16'd3);
    step("halt_hold", F_HALT, 16'd3);

    // Restart from HALT clears the counter
    bus.start = 1'b1;
    step("halt_start", F_HALT, 16'd3);
    clr();
    step("boot2", F_BOOT, 16'd0);
    bus.endProgram = 1'b1; bus.branchTaken = 1'b1;
    step("run2_end_br", F_REDIR, 16'd0);
    clr();
    step("run2_stay", F_RUN, 16'd0);
    bus.regWriteEx = 1'b1; bus.branchRegId = 1'b1; bus.rdEx = 5'd4; bus.rs1Id = 5'd4;
    step("run2_br_haz", F_STALL, 16'd0);
    clr();
    bus.endProgram = 1'b1;
    step("run2_end", F_RUN, 16'd1);
    clr();
    step("drain2", F_DRAIN, 16'd1);

    // Asynchronous reset mid-drain
    #2;
    resetN = 1'b0;
    #1;
    expect_out("reset_drain", F_IDLE, 16'd0);
    check();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    step("idle_again", F_IDLE, 16'd0);

    // Saturation
    bus.start = 1'b1;
    step("start3", F_IDLE, 16'd0);
    clr();
    step("boot3", F_BOOT, 16'd0);
    bus.memReadEx = 1'b1; bus.rdEx = 5'd31; bus.rs1Id = 5'd31; bus.useRs1Id = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    step("near_sat", F_STALL, 16'hFFFE);
    repeat (10) @(posedge clk);
    #1;
    step("sat", F_STALL, 16'hFFFF);
    step("sat_hold", F_STALL, 16'hFFFF);
    clr();
    step("sat_release", F_RUN, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
